// File: rtl/mcdf_pkg.sv
// ============================================================================
// Module      : mcdf_pkg
// Description : Shared types and constants for the MCDF formatter receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcdf_pkg;

    localparam int c_ID_W   = 2;
    localparam int c_DATA_W = 32;
    localparam int c_LEN_W  = 6;

    localparam logic [c_LEN_W-1:0] c_LEN_4  = 6'd4;
    localparam logic [c_LEN_W-1:0] c_LEN_8  = 6'd8;
    localparam logic [c_LEN_W-1:0] c_LEN_16 = 6'd16;
    localparam logic [c_LEN_W-1:0] c_LEN_32 = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_RECV       = 2'd3
    } fmt_state_t;

    typedef struct packed {
        logic                last;
        logic [c_ID_W-1:0]   id;
        logic [c_DATA_W-1:0] data;
    } fifo_entry_t;

    localparam int c_ENTRY_W = $bits(fifo_entry_t);

    function automatic logic is_legal_len(input logic [c_LEN_W-1:0] len);
        return (len == c_LEN_4) || (len == c_LEN_8) || (len == c_LEN_16) || (len == c_LEN_32);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcdf_sync_fifo.sv
// ============================================================================
// Module      : mcdf_sync_fifo
// Description : First-word-fall-through synchronous FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcdf_sync_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_used
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_hold;
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign o_used  = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;

    // While empty, the last word handed out stays on the output
    assign o_rdata = o_empty ? r_hold : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_hold   <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcdf_fmt_rx.sv
// ============================================================================
// Module      : mcdf_fmt_rx
// Description : Formatter receive side: grant arbitration, packet capture, framed output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcdf_fmt_rx
    import mcdf_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int TMO_CYCLES = 16,
    parameter int PKTCNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 fmt_req_i,
    output logic                 fmt_grant_o,
    input  logic [1:0]           fmt_child_i,
    input  logic [5:0]           fmt_length_i,
    input  logic                 fmt_start_i,
    input  logic                 fmt_end_i,
    input  logic [31:0]          fmt_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [31:0]          rd_data_o,
    output logic [1:0]           rd_id_o,
    output logic                 rd_last_o,
    output logic                 len_err_o,
    output logic                 tmo_err_o,
    output logic [PKTCNT_W-1:0]  pkt_cnt_o
);

    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_TMO_W = $clog2(TMO_CYCLES) + 1;
    localparam logic [c_LEN_W-1:0] c_CNT_MAX = '1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYCLES - 1);
    localparam logic [c_AW:0]      c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);

    fmt_state_t            r_state;
    fmt_state_t            w_next;
    logic [c_ID_W-1:0]     r_child;
    logic [c_LEN_W-1:0]    r_len;
    logic [c_LEN_W-1:0]    r_cnt;
    logic [c_LEN_W-1:0]    w_total;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_len_err;
    logic                  r_tmo_err;
    logic [PKTCNT_W-1:0]   r_pkt_cnt;

    logic                  w_word;
    logic                  w_push;
    logic                  w_last;
    logic                  w_end_hit;
    logic                  w_tmo_hit;
    logic                  w_pop;
    logic                  w_empty;
    logic [c_AW:0]         w_used;
    logic [c_AW:0]         w_free;
    fifo_entry_t           w_wr_entry;
    fifo_entry_t           w_rd_entry;

    assign w_free  = c_DEPTH - w_used;
    assign w_total = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Words beyond the latched length are counted but never stored
    assign w_push    = w_word && (r_cnt < r_len);
    assign w_last    = fmt_end_i || (r_cnt == r_len - 1'b1);
    assign w_end_hit = w_word && fmt_end_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_word    = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fmt_req_i && is_legal_len(fmt_length_i) &&
                    (w_free >= (c_AW + 1)'(fmt_length_i))) begin
                    w_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (fmt_start_i) begin
                    w_word = 1'b1;
                    w_next = fmt_end_i ? ST_IDLE : ST_RECV;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_RECV: begin
                w_word = 1'b1;
                if (fmt_end_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_child   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_tmo_cnt <= '0;
            r_len_err <= 1'b0;
            r_tmo_err <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_len_err <= w_end_hit && (w_total != r_len);
            r_tmo_err <= w_tmo_hit;
            // Capture the packet header that passed the space check
            if ((r_state == ST_IDLE) && (w_next == ST_GRANT)) begin
                r_child <= fmt_child_i;
                r_len   <= fmt_length_i;
            end
            if (r_state == ST_GRANT) begin
                r_cnt     <= '0;
                r_tmo_cnt <= '0;
            end else begin
                if (w_word) begin
                    r_cnt <= w_total;
                end
                if (r_state == ST_WAIT_START) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
            if (w_push && w_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign w_wr_entry = '{last: w_last, id: r_child, data: fmt_data_i};
    assign w_pop      = rd_valid_o && rd_ready_i;

    mcdf_sync_fifo #(
        .W     (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_rd_entry),
        .o_empty (w_empty),
        .o_used  (w_used)
    );

    assign fmt_grant_o = (r_state == ST_GRANT);
    assign rd_valid_o  = !w_empty;
    assign rd_data_o   = w_rd_entry.data;
    assign rd_id_o     = w_rd_entry.id;
    assign rd_last_o   = w_rd_entry.last;
    assign len_err_o   = r_len_err;
    assign tmo_err_o   = r_tmo_err;
    assign pkt_cnt_o   = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mcdf_fmt_rx.sv
// ============================================================================
// Module      : tb_mcdf_fmt_rx
// Description : Directed vector bench for mcdf_fmt_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcdf_fmt_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fmt_req = 1'b0;
    logic        fmt_grant;
    logic [1:0]  fmt_child = 2'd0;
    logic [5:0]  fmt_length = 6'd0;
    logic        fmt_start = 1'b0;
    logic        fmt_end = 1'b0;
    logic [31:0] fmt_data = 32'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [1:0]  rd_id;
    logic        rd_last;
    logic        len_err;
    logic        tmo_err;
    logic [15:0] pkt_cnt;

    mcdf_fmt_rx #(
        .FIFO_DEPTH (64),
        .TMO_CYCLES (16),
        .PKTCNT_W   (16)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .fmt_req_i    (fmt_req),
        .fmt_grant_o  (fmt_grant),
        .fmt_child_i  (fmt_child),
        .fmt_length_i (fmt_length),
        .fmt_start_i  (fmt_start),
        .fmt_end_i    (fmt_end),
        .fmt_data_i   (fmt_data),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data),
        .rd_id_o      (rd_id),
        .rd_last_o    (rd_last),
        .len_err_o    (len_err),
        .tmo_err_o    (tmo_err),
        .pkt_cnt_o    (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [1:0]  id;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [1:0]  id;
        logic [5:0]  len;
        int          nsent;
        logic [31:0] base;
        bit          exp_grant;
        int          exp_wr;
        bit          exp_err;
    } vec_t;

    ent_t exp_q[$];
    ent_t cap_q[$];
    int   cap_idx   = 0;
    int   n_cmp     = 0;
    int   n_mis     = 0;
    int   grant_cnt = 0;
    int   lerr_cnt  = 0;
    int   terr_cnt  = 0;
    bit   tog_en    = 1'b0;

    // Transfers and pulses observed mid-cycle
    always @(negedge clk) begin
        if (rstn) begin
            if (rd_valid && rd_ready) cap_q.push_back({rd_last, rd_id, rd_data});
            if (fmt_grant) grant_cnt++;
            if (len_err)   lerr_cnt++;
            if (tmo_err)   terr_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) rd_ready = ~rd_ready;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] id, input logic [5:0] len, input int budget,
                              output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        fmt_req    = 1'b1;
        fmt_child  = id;
        fmt_length = len;
        for (int k = 1; k <= budget && !got; k++) begin
            step();
            if (fmt_grant) begin
                got = 1'b1;
                lat = k;
            end
        end
        fmt_req = 1'b0;
    endtask

    // Called in the grant cycle; the packet starts on the following cycle
    task automatic send_words(input logic [1:0] id, input logic [5:0] len, input int n,
                              input logic [31:0] base);
        int   nw;
        ent_t e;
        nw = (n < int'(len)) ? n : int'(len);
        step();
        for (int i = 0; i < n; i++) begin
            fmt_start = (i == 0);
            fmt_end   = (i == n - 1);
            fmt_data  = base + 32'(i);
            if (i < nw) begin
                e = {(i == nw - 1), id, base + 32'(i)};
                exp_q.push_back(e);
            end
            step();
        end
        fmt_start = 1'b0;
        fmt_end   = 1'b0;
        fmt_data  = 32'd0;
    endtask

    task automatic check_drain(input string tag, input int exp_cnt);
        int got_cnt;
        tog_en   = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 600 && rd_valid; k++) step();
        step();
        step();
        got_cnt = cap_q.size() - cap_idx;
        chk({tag, "_count"}, longint'(got_cnt), longint'(exp_cnt));
        for (int i = 0; i < exp_q.size() && (cap_idx + i) < cap_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), longint'(cap_q[cap_idx + i]), longint'(exp_q[i]));
        end
        cap_idx = cap_q.size();
        exp_q.delete();
    endtask

    vec_t   vt[8];
    bit     got;
    int     lat;
    longint pk0;
    int     g0, le0, t0, tmo_at;

    initial begin
        vt[0] = '{2'd1, 6'd4,  4,  32'h000000A0, 1'b1, 4,  1'b0};
        vt[1] = '{2'd2, 6'd8,  6,  32'h00000100, 1'b1, 6,  1'b1};
        vt[2] = '{2'd0, 6'd8,  10, 32'h00000200, 1'b1, 8,  1'b1};
        vt[3] = '{2'd2, 6'd16, 16, 32'h00000300, 1'b1, 16, 1'b0};
        vt[4] = '{2'd1, 6'd32, 32, 32'h00000400, 1'b1, 32, 1'b0};
        vt[5] = '{2'd0, 6'd4,  1,  32'h00000500, 1'b1, 1,  1'b1};
        vt[6] = '{2'd1, 6'd5,  0,  32'h00000000, 1'b0, 0,  1'b0};
        vt[7] = '{2'd2, 6'd0,  0,  32'h00000000, 1'b0, 0,  1'b0};

        // Reset state
        repeat (3) step();
        rstn = 1'b1;
        #1;
        chk("rst_grant",   longint'(fmt_grant), 0);
        chk("rst_valid",   longint'(rd_valid),  0);
        chk("rst_data",    longint'(rd_data),   0);
        chk("rst_id",      longint'(rd_id),     0);
        chk("rst_last",    longint'(rd_last),   0);
        chk("rst_len_err", longint'(len_err),   0);
        chk("rst_tmo_err", longint'(tmo_err),   0);
        chk("rst_pkt_cnt", longint'(pkt_cnt),   0);

        // Table vectors, downstream always ready
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pk0 = longint'(pkt_cnt);
            g0  = grant_cnt;
            le0 = lerr_cnt;
            wait_grant(vt[i].id, vt[i].len, 20, got, lat);
            chk($sformatf("v%0d_grant", i), longint'(got), longint'(vt[i].exp_grant));
            if (got) begin
                if (i == 0) chk("v0_grant_latency", longint'(lat), 1);
                send_words(vt[i].id, vt[i].len, vt[i].nsent, vt[i].base);
                chk($sformatf("v%0d_len_err_now", i), longint'(len_err), longint'(vt[i].exp_err));
            end
            check_drain($sformatf("v%0d", i), vt[i].exp_wr);
            chk($sformatf("v%0d_pkt_inc", i), longint'(pkt_cnt) - pk0, longint'(vt[i].exp_grant));
            chk($sformatf("v%0d_len_err_pulses", i), longint'(lerr_cnt - le0), longint'(vt[i].exp_err));
            chk($sformatf("v%0d_grant_pulses", i), longint'(grant_cnt - g0), longint'(vt[i].exp_grant));
        end

        // Space check: 48 words parked, a 32-word packet must wait for 16 pops
        rd_ready = 1'b0;
        wait_grant(2'd0, 6'd32, 20, got, lat);
        chk("space_g0", longint'(got), 1);
        send_words(2'd0, 6'd32, 32, 32'h00001000);
        wait_grant(2'd1, 6'd16, 20, got, lat);
        chk("space_g1", longint'(got), 1);
        send_words(2'd1, 6'd16, 16, 32'h00002000);
        g0 = grant_cnt;
        fmt_req    = 1'b1;
        fmt_child  = 2'd2;
        fmt_length = 6'd32;
        repeat (20) step();
        chk("space_blocked", longint'(grant_cnt - g0), 0);
        rd_ready = 1'b1;
        repeat (16) step();
        rd_ready = 1'b0;
        chk("space_blocked_pop", longint'(grant_cnt - g0), 0);
        step();
        chk("space_grant", longint'(fmt_grant), 1);
        fmt_req = 1'b0;
        send_words(2'd2, 6'd32, 32, 32'h00003000);
        check_drain("space", 80);

        // Start timeout
        pk0 = longint'(pkt_cnt);
        g0  = grant_cnt;
        t0  = terr_cnt;
        wait_grant(2'd1, 6'd4, 20, got, lat);
        chk("tmo_grant", longint'(got), 1);
        tmo_at = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (tmo_err && tmo_at == 0) tmo_at = k;
        end
        chk("tmo_cycle",  longint'(tmo_at), 17);
        chk("tmo_pulses", longint'(terr_cnt - t0), 1);
        chk("tmo_grants", longint'(grant_cnt - g0), 1);
        chk("tmo_empty",  longint'(rd_valid), 0);
        chk("tmo_pkt",    longint'(pkt_cnt) - pk0, 0);
        fmt_start = 1'b1;
        fmt_end   = 1'b1;
        fmt_data  = 32'hDEADBEEF;
        step();
        fmt_start = 1'b0;
        fmt_end   = 1'b0;
        step();
        chk("stray_strobe_ignored", longint'(rd_valid), 0);
        wait_grant(2'd1, 6'd4, 20, got, lat);
        chk("regrant", longint'(got), 1);
        send_words(2'd1, 6'd4, 4, 32'h00004000);
        check_drain("regrant", 4);

        // Back-to-back max packets with downstream toggling
        tog_en   = 1'b1;
        rd_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_grant(2'(p), 6'd32, 300, got, lat);
            chk($sformatf("b2b_grant%0d", p), longint'(got), 1);
            send_words(2'(p), 6'd32, 32, 32'h00005000 + 32'(p * 256));
        end
        check_drain("b2b", 96);

        // Reset in the middle of a packet
        rd_ready = 1'b0;
        wait_grant(2'd2, 6'd32, 20, got, lat);
        chk("rstmid_grant", longint'(got), 1);
        step();
        for (int i = 0; i < 10; i++) begin
            fmt_start = (i == 0);
            fmt_data  = 32'h00006000 + 32'(i);
            step();
        end
        chk("rstmid_pre_valid", longint'(rd_valid), 1);
        rstn = 1'b0;
        #1;
        chk("rstmid_valid",   longint'(rd_valid),  0);
        chk("rstmid_data",    longint'(rd_data),   0);
        chk("rstmid_id",      longint'(rd_id),     0);
        chk("rstmid_last",    longint'(rd_last),   0);
        chk("rstmid_pkt_cnt", longint'(pkt_cnt),   0);
        chk("rstmid_grant_o", longint'(fmt_grant), 0);
        chk("rstmid_errs",    longint'({len_err, tmo_err}), 0);
        fmt_start = 1'b0;
        fmt_data  = 32'd0;
        step();
        step();
        rstn = 1'b1;
        cap_idx = cap_q.size();
        exp_q.delete();
        wait_grant(2'd1, 6'd4, 20, got, lat);
        chk("post_rst_grant", longint'(got), 1);
        send_words(2'd1, 6'd4, 4, 32'h00007000);
        check_drain("post_rst", 4);
        chk("post_rst_pkt_cnt", longint'(pkt_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
